// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_pkg: forward-select codes and multi-cycle FSM state type shared by the hazard controller
package pipe_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  typedef enum logic {IDLE, BUSY} mc_state_t;
endpackage

// File: rtl/pipe_hazard_ctrl_sat_counter.sv
// sat_counter: W-bit up-counter that sticks at all-ones
//   clk, rst (sync, active high), inc (count enable) -> cnt
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk)
    cnt <= rst ? '0 : (inc && !(&cnt)) ? cnt + W'(1) : cnt;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline forwarding, load-use stall, branch flush and multi-cycle EX stall control
//   inputs : clk, rst, register numbers per stage, write enables, loadE/pcsrcE/mcstartE
//   outputs: forwardAE/BE mux selects, stallF/D/E, flushD/E/M, mcdoneE, stall_cnt/flush_cnt
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int RA_W   = 5,
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [RA_W-1:0]  rs1D,
  input  logic [RA_W-1:0]  rs2D,
  input  logic [RA_W-1:0]  rs1E,
  input  logic [RA_W-1:0]  rs2E,
  input  logic [RA_W-1:0]  rdE,
  input  logic [RA_W-1:0]  rdM,
  input  logic [RA_W-1:0]  rdW,
  input  logic             regwriteM,
  input  logic             regwriteW,
  input  logic             loadE,
  input  logic             pcsrcE,
  input  logic             mcstartE,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             stallF,
  output logic             stallD,
  output logic             stallE,
  output logic             flushD,
  output logic             flushE,
  output logic             flushM,
  output logic             mcdoneE,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int MC_W = $clog2(MC_LAT);
  mc_state_t state, state_n;
  logic [MC_W-1:0] cnt, cnt_n;
  logic lwstall, mc_stall, br;
  assign forwardAE = rst ? FWD_RF
                   : (regwriteM && rdM != '0 && rdM == rs1E) ? FWD_MEM
                   : (regwriteW && rdW != '0 && rdW == rs1E) ? FWD_WB : FWD_RF;
  assign forwardBE = rst ? FWD_RF
                   : (regwriteM && rdM != '0 && rdM == rs2E) ? FWD_MEM
                   : (regwriteW && rdW != '0 && rdW == rs2E) ? FWD_WB : FWD_RF;
  assign lwstall = !rst && loadE && rdE != '0 && (rdE == rs1D || rdE == rs2D);
  // a stalled E cannot hold a new branch, so pcsrcE only counts while idle
  assign br = !rst && pcsrcE && state == IDLE;
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    mc_stall = 1'b0;
    mcdoneE  = 1'b0;
    if (state == IDLE) begin
      if (mcstartE && !pcsrcE) begin
        mc_stall = 1'b1;
        cnt_n    = MC_W'(MC_LAT - 2);
        state_n  = BUSY;
      end
    end else if (cnt != '0) begin
      mc_stall = 1'b1;
      cnt_n    = cnt - MC_W'(1);
    end else begin
      mcdoneE = 1'b1;
      state_n = IDLE;
    end
    if (rst) begin
      mc_stall = 1'b0;
      mcdoneE  = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    state <= rst ? IDLE : state_n;
    cnt   <= rst ? '0 : cnt_n;
  end
  assign stallF = mc_stall || lwstall;
  assign stallD = mc_stall || lwstall;
  assign stallE = mc_stall;
  assign flushD = br;
  // never bubble E while it holds a multi-cycle op
  assign flushE = br || (lwstall && !mc_stall);
  assign flushM = mc_stall;
  sat_counter #(.W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(stallF), .cnt(stall_cnt));
  sat_counter #(.W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(flushD || flushE), .cnt(flush_cnt));
endmodule
